// File: rtl/stack_op_pkg.sv
// ----------------------------------------------------------------------------
// stack_op_pkg
// Shared types and constants for the stack-op sequencer and its ALU.
//   - op_e      : 3-bit opcode encoding
//   - state_e   : sequencer FSM states
//   - ERR_*     : err_code values
//   - is_binary : true for ops that pop two operands
// Build option: define STACK_OP_MUL_EN to turn opcode 000 into MUL (b*a)
// instead of NOP.
// ----------------------------------------------------------------------------
package stack_op_pkg;

   localparam int DEPTH_DEF = 32;
   localparam int W_DEF     = 8;

   typedef enum logic [2:0] {
`ifdef STACK_OP_MUL_EN
      OP_MUL   = 3'b000,
`else
      OP_NOP   = 3'b000,
`endif
      OP_PUSHI = 3'b001,
      OP_POP   = 3'b010,
      OP_DUP   = 3'b011,
      OP_ADD   = 3'b100,
      OP_SUB   = 3'b101,
      OP_AND   = 3'b110,
      OP_NOT   = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_POP1    = 3'd1,
      S_TOS1    = 3'd2,
      S_CAP1    = 3'd3,
      S_CAP2    = 3'd4,
      S_PUSH    = 3'd5,
      S_POPDONE = 3'd6,
      S_ERR     = 3'd7
   } state_e;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_UNDER = 2'b01;
   localparam logic [1:0] ERR_OVER  = 2'b10;

   function automatic logic is_binary(op_e op);
      logic bin;
      bin = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
`ifdef STACK_OP_MUL_EN
      bin = bin || (op == OP_MUL);
`endif
      return bin;
   endfunction

endpackage

// File: rtl/stack_op_alu.sv
// ----------------------------------------------------------------------------
// stack_op_alu
// Combinational result generator for the stack-op sequencer.
// Ports:
//   op     in  opcode of the op in flight
//   a      in  top-of-stack operand
//   b      in  second-from-top operand (binary ops only)
//   imm    in  immediate for PUSHI
//   result out op result, modulo 2^W
// Build option: STACK_OP_MUL_EN adds the b*a multiplier on opcode 000.
// ----------------------------------------------------------------------------
module stack_op_alu
   import stack_op_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  op_e          op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] imm,
   output logic [W-1:0] result
);

   always_comb begin
      // NOTE: result gets a value on every path before the case, so no latch
      // can be inferred when an opcode has no arm here.
      result = '0;
      case (op)
`ifdef STACK_OP_MUL_EN
         OP_MUL:   result = b * a;   // low W bits only
`endif
         OP_PUSHI: result = imm;
         OP_DUP:   result = a;
         OP_ADD:   result = b + a;
         OP_SUB:   result = b - a;
         OP_AND:   result = b & a;
         OP_NOT:   result = ~a;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/stack_op_seq.sv
// ----------------------------------------------------------------------------
// stack_op_seq
// Multicycle sequencer in front of the CPU operand stack. Accepts one op per
// in_valid/in_ready handshake, expands it into pop / read-top / push strobes,
// and tracks the stack depth so underflow and overflow are rejected before
// the stack pointer can wrap.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  op handshake (ready only in IDLE)
//   in_op, in_imm   opcode and PUSHI immediate
//   stk_dout        stack read data, valid the cycle after stk_pop/stk_tos
//   stk_din         data to stack (push cycle only)
//   stk_push/pop/tos  stack command strobes, at most one per cycle
//   res_valid/data  one-cycle completion pulse with result or popped value
//   err, err_code   one-cycle rejection pulse, 01 underflow / 10 overflow
//   depth           current number of stack entries
// Build option: STACK_OP_MUL_EN makes opcode 000 a MUL with ADD timing.
// ----------------------------------------------------------------------------
module stack_op_seq
   import stack_op_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int W     = W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_op,
   input  logic [W-1:0]             in_imm,
   input  logic [W-1:0]             stk_dout,
   output logic [W-1:0]             stk_din,
   output logic                     stk_push,
   output logic                     stk_pop,
   output logic                     stk_tos,
   output logic                     res_valid,
   output logic [W-1:0]             res_data,
   output logic                     err,
   output logic [1:0]               err_code,
   output logic [$clog2(DEPTH):0]   depth
);

   localparam int              DW   = $clog2(DEPTH) + 1;
   localparam logic [DW-1:0]   FULL = DW'(DEPTH);

   state_e         r_state, w_state_nxt;
   op_e            r_op;
   logic [W-1:0]   r_imm, r_a, r_b;
   logic [1:0]     r_err_code, w_chk_code;
   logic           r_nop_done;
   logic [DW-1:0]  r_depth;
   logic [W-1:0]   w_result;
   op_e            w_in_op;
   logic           w_accept;

   assign w_in_op  = op_e'(in_op);
   assign w_accept = (r_state == S_IDLE) && in_valid;

   // Depth requirement of the op being offered; underflow wins over overflow.
   always_comb begin
      w_chk_code = ERR_NONE;
      case (w_in_op)
         OP_PUSHI: if (r_depth == FULL) w_chk_code = ERR_OVER;
         OP_POP,
         OP_NOT:   if (r_depth == '0)   w_chk_code = ERR_UNDER;
         OP_DUP: begin
            if (r_depth == '0)        w_chk_code = ERR_UNDER;
            else if (r_depth == FULL) w_chk_code = ERR_OVER;
         end
         default:  if (is_binary(w_in_op) && (r_depth < DW'(2))) w_chk_code = ERR_UNDER;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               if (w_chk_code != ERR_NONE) begin
                  w_state_nxt = S_ERR;
               end else begin
                  case (w_in_op)
                     OP_PUSHI:       w_state_nxt = S_PUSH;
                     OP_POP, OP_NOT: w_state_nxt = S_POP1;
                     OP_DUP:         w_state_nxt = S_TOS1;
                     // NOP stays in IDLE; binary ops start with a pop.
                     default:        w_state_nxt = is_binary(w_in_op) ? S_POP1 : S_IDLE;
                  endcase
               end
            end
         end
         S_POP1:  w_state_nxt = (r_op == OP_POP) ? S_POPDONE : S_CAP1;
         S_TOS1:  w_state_nxt = S_CAP1;
         S_CAP1:  w_state_nxt = is_binary(r_op) ? S_CAP2 : S_PUSH;
         S_CAP2:  w_state_nxt = S_PUSH;
         default: w_state_nxt = S_IDLE;  // PUSH, POPDONE, ERR
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_op       <= op_e'(3'b000);
         r_imm      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_err_code <= ERR_NONE;
         r_nop_done <= 1'b0;
         r_depth    <= '0;
      end else begin
         r_state <= w_state_nxt;
         // A clean accept that stays in IDLE is a NOP; it completes next cycle.
         r_nop_done <= w_accept && (w_chk_code == ERR_NONE) && (w_state_nxt == S_IDLE);
         if (w_accept) begin
            r_op       <= w_in_op;
            r_imm      <= in_imm;
            r_err_code <= w_chk_code;
         end
         if (r_state == S_CAP1) r_a <= stk_dout;
         if (r_state == S_CAP2) r_b <= stk_dout;
         if (stk_push)     r_depth <= r_depth + DW'(1);
         else if (stk_pop) r_depth <= r_depth - DW'(1);
      end
   end

   stack_op_alu #(.W(W)) u_alu (
      .op     (r_op),
      .a      (r_a),
      .b      (r_b),
      .imm    (r_imm),
      .result (w_result)
   );

   // Binary ops pop the second operand in CAP1 while capturing the first.
   assign stk_pop   = (r_state == S_POP1) || ((r_state == S_CAP1) && is_binary(r_op));
   assign stk_tos   = (r_state == S_TOS1);
   assign stk_push  = (r_state == S_PUSH);
   assign stk_din   = stk_push ? w_result : '0;

   assign in_ready  = (r_state == S_IDLE);
   assign res_valid = stk_push || (r_state == S_POPDONE) || r_nop_done;
   assign res_data  = stk_push ? w_result :
                      (r_state == S_POPDONE) ? stk_dout : '0;
   assign err       = (r_state == S_ERR);
   assign err_code  = err ? r_err_code : ERR_NONE;
   assign depth     = r_depth;

endmodule
